// File: rtl/fetch_if.sv
// Bus between the fetch unit and the decode/register-file side of the core:
// instruction fetch, decoded fields, decoder strobes and statistics.
interface fetch_if #(
    parameter int IMEM_AW = 10,
    parameter int CNT_W   = 32
);
  logic [31:0]        instr;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        pc;
  logic [31:0]        pc_plus4;
  logic [5:0]         op;
  logic [5:0]         func;
  logic [4:0]         rs;
  logic [4:0]         rt;
  logic [4:0]         rd;
  logic [4:0]         shamt;
  logic [15:0]        imm16;
  logic [25:0]        target26;
  logic               jmp, jr, jal, beq, bne, bltz, blez, bgez, bgtz, syscall;
  logic [31:0]        rs_data;
  logic [31:0]        rt_data;
  logic [31:0]        v0_data;
  logic               go;
  logic               halted;
  logic [CNT_W-1:0]   cycle_cnt;
  logic [CNT_W-1:0]   uncond_cnt;
  logic [CNT_W-1:0]   cond_taken_cnt;

  modport master (
    input  instr, jmp, jr, jal, beq, bne, bltz, blez, bgez, bgtz, syscall,
           rs_data, rt_data, v0_data, go,
    output imem_addr, pc, pc_plus4, op, func, rs, rt, rd, shamt, imm16,
           target26, halted, cycle_cnt, uncond_cnt, cond_taken_cnt
  );

  modport slave (
    output instr, jmp, jr, jal, beq, bne, bltz, blez, bgez, bgtz, syscall,
           rs_data, rt_data, v0_data, go,
    input  imem_addr, pc, pc_plus4, op, func, rs, rt, rd, shamt, imm16,
           target26, halted, cycle_cnt, uncond_cnt, cond_taken_cnt
  );
endinterface

// File: rtl/fetch_unit.sv
// PC register, instruction field split, next-PC selection, syscall halt/resume
// and control-flow statistics for the single-cycle MIPS core.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 10,
    parameter logic [31:0] HALT_CODE = 32'd10,
    parameter int          CNT_W     = 32
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
);
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [31:0]      pc_reg, pc_next;
  logic [31:0]      pc_plus4, branch_target, jump_target;
  logic [CNT_W-1:0] cycle_reg, cycle_next;
  logic [CNT_W-1:0] uncond_reg, uncond_next;
  logic [CNT_W-1:0] cond_reg, cond_next;
  logic             rs_neg, rs_zero, take, halt_event;

  assign pc_plus4      = pc_reg + 32'd4;
  assign branch_target = pc_plus4 + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
  assign jump_target   = {pc_plus4[31:28], bus.instr[25:0], 2'b00};

  assign rs_neg  = bus.rs_data[31];
  assign rs_zero = (bus.rs_data == 32'd0);
  assign take    = (bus.beq  & (bus.rs_data == bus.rt_data))
                 | (bus.bne  & (bus.rs_data != bus.rt_data))
                 | (bus.bltz & rs_neg)
                 | (bus.blez & (rs_neg | rs_zero))
                 | (bus.bgez & ~rs_neg)
                 | (bus.bgtz & ~rs_neg & ~rs_zero);

  assign halt_event = (state_reg == RUN) && bus.syscall && (bus.v0_data == HALT_CODE);

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    cycle_next  = cycle_reg;
    uncond_next = uncond_reg;
    cond_next   = cond_reg;
    case (state_reg)
      RUN: begin
        // Counters include the edge that enters HALT.
        cycle_next = cycle_reg + CNT_W'(1);
        if (bus.jmp) uncond_next = uncond_reg + CNT_W'(1);
        if (take)    cond_next   = cond_reg + CNT_W'(1);
        if (halt_event)   state_next = HALT;
        else if (bus.jr)  pc_next = bus.rs_data;
        else if (bus.jmp) pc_next = jump_target;
        else if (take)    pc_next = branch_target;
        else              pc_next = pc_plus4;
      end
      HALT: begin
        // Resume steps past the halting syscall, so a held go fires once.
        if (bus.go) begin
          pc_next    = pc_plus4;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      pc_reg     <= RESET_PC;
      cycle_reg  <= '0;
      uncond_reg <= '0;
      cond_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      pc_reg     <= pc_next;
      cycle_reg  <= cycle_next;
      uncond_reg <= uncond_next;
      cond_reg   <= cond_next;
    end
  end

  assign bus.pc             = pc_reg;
  assign bus.pc_plus4       = pc_plus4;
  assign bus.imem_addr      = pc_reg[IMEM_AW+1:2];
  assign bus.op             = bus.instr[31:26];
  assign bus.rs             = bus.instr[25:21];
  assign bus.rt             = bus.instr[20:16];
  assign bus.rd             = bus.instr[15:11];
  assign bus.shamt          = bus.instr[10:6];
  assign bus.func           = bus.instr[5:0];
  assign bus.imm16          = bus.instr[15:0];
  assign bus.target26       = bus.instr[25:0];
  assign bus.halted         = (state_reg == HALT);
  assign bus.cycle_cnt      = cycle_reg;
  assign bus.uncond_cnt     = uncond_reg;
  assign bus.cond_taken_cnt = cond_reg;
endmodule
